// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter
// Round-robin arbiter and frame sequencer. Several bus masters share one
// serial slave port. The arbiter grants one master at a time and routes
// that master's serial address/data lines to the slave. It also generates
// the slave framing strobes, passes read data back and aborts reads whose
// data never arrives.
//
// Ports
//   clk, rstn        bus clock (rising edge), async active-low reset
//   m_req            per-master request level, sampled in IDLE only
//   m_write          per-master direction (1 write, 0 read), latched at grant
//   m_addr_bit       per-master serial address line, LSB first
//   m_data_bit       per-master serial write-data line, LSB first
//   m_grant          one-hot grant, registered
//   m_done           one-cycle completion pulse to the granted master
//   m_timeout        one-cycle pulse with m_done when a read was aborted
//   m_rdata_bit      slave read data bit (valid when m_rdata_valid)
//   m_rdata_valid    read data qualifier
//   bus_busy         high in every state except IDLE
//   rx_address       serial address line to the slave
//   rx_data          serial write-data line to the slave
//   write_enable     write frame-start strobe (first SHIFT cycle)
//   read_enable      read frame-start strobe (first SHIFT cycle)
//   m_valid          high while a frame shifts to the slave
//   s_valid          slave read data valid
//   tx_data          slave serial read data
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | bus free; pick the next requester round-robin
// S_GRANT | one-cycle master turnaround; master drives bit 0 next
// S_SHIFT | address (and write data) shifting to the slave
// S_WAIT  | read issued; waiting for the first s_valid, with timeout
// S_RDATA | collecting the remaining read bits, gaps allowed
// S_DONE  | one-cycle completion pulse; grant already cleared
module serial_bus_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_MASTERS-1:0] m_req,
  input  logic [N_MASTERS-1:0] m_write,
  input  logic [N_MASTERS-1:0] m_addr_bit,
  input  logic [N_MASTERS-1:0] m_data_bit,
  output logic [N_MASTERS-1:0] m_grant,
  output logic [N_MASTERS-1:0] m_done,
  output logic                 m_timeout,
  output logic                 m_rdata_bit,
  output logic                 m_rdata_valid,
  output logic                 bus_busy,
  output logic                 rx_address,
  output logic                 rx_data,
  output logic                 write_enable,
  output logic                 read_enable,
  output logic                 m_valid,
  input  logic                 s_valid,
  input  logic                 tx_data
);

  localparam int SHIFT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int IW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int BW  = $clog2(SHIFT_MAX + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int DCW = $clog2(DATA_WIDTH + 1);
  localparam logic [N_MASTERS-1:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_SHIFT, S_WAIT, S_RDATA, S_DONE
  } state_t;

  state_t               state_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [N_MASTERS-1:0] done_q;
  logic [IW-1:0]        gidx_q;
  logic [IW-1:0]        last_q;
  logic                 write_q;
  logic                 timeout_q;
  logic                 we_q;
  logic                 re_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [TW-1:0]        to_cnt_q;
  logic [DCW-1:0]       dcnt_q;

  logic                 pick_found_d;
  logic [IW-1:0]        pick_idx_d;
  logic                 shift_last;
  logic                 in_shift;
  logic                 in_read;

  // Search starts one past the last winner so the previous owner has
  // lowest priority on the next arbitration.
  always_comb begin : pick_blk
    logic [IW-1:0] cand;
    cand         = '0;
    pick_found_d = 1'b0;
    pick_idx_d   = last_q;
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand = IW'((int'(last_q) + i) % N_MASTERS);
      if (!pick_found_d && m_req[cand]) begin
        pick_found_d = 1'b1;
        pick_idx_d   = cand;
      end
    end
  end

  assign shift_last = write_q ? (bit_cnt_q == BW'(SHIFT_MAX - 1))
                              : (bit_cnt_q == BW'(ADDR_WIDTH - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      gidx_q    <= '0;
      last_q    <= IW'(N_MASTERS - 1);
      write_q   <= 1'b0;
      timeout_q <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      dcnt_q    <= '0;
    end else begin
      done_q    <= '0;
      timeout_q <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_found_d) begin
            grant_q <= ONE << pick_idx_d;
            gidx_q  <= pick_idx_d;
            last_q  <= pick_idx_d;
            write_q <= m_write[pick_idx_d];
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          bit_cnt_q <= '0;
          we_q      <= write_q;
          re_q      <= !write_q;
          state_q   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (shift_last) begin
            bit_cnt_q <= '0;
            if (write_q) begin
              grant_q <= '0;
              done_q  <= ONE << gidx_q;
              state_q <= S_DONE;
            end else begin
              to_cnt_q <= '0;
              state_q  <= S_WAIT;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BW'(1);
          end
        end
        S_WAIT: begin
          if (s_valid) begin
            // This cycle already carries read bit 0.
            dcnt_q <= DCW'(1);
            if (DATA_WIDTH == 1) begin
              grant_q <= '0;
              done_q  <= ONE << gidx_q;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RDATA;
            end
          end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
            grant_q   <= '0;
            done_q    <= ONE << gidx_q;
            timeout_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        S_RDATA: begin
          if (s_valid) begin
            if (dcnt_q == DCW'(DATA_WIDTH - 1)) begin
              grant_q <= '0;
              done_q  <= ONE << gidx_q;
              state_q <= S_DONE;
            end else begin
              dcnt_q <= dcnt_q + DCW'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          grant_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_shift = (state_q == S_SHIFT);
  assign in_read  = (state_q == S_WAIT) || (state_q == S_RDATA);

  assign m_grant       = grant_q;
  assign m_done        = done_q;
  assign m_timeout     = timeout_q;
  assign write_enable  = we_q;
  assign read_enable   = re_q;
  assign bus_busy      = (state_q != S_IDLE);
  assign m_valid       = in_shift;
  assign rx_address    = in_shift & m_addr_bit[gidx_q];
  // Reads carry no write data; keep the line quiet.
  assign rx_data       = in_shift & write_q & m_data_bit[gidx_q];
  assign m_rdata_valid = in_read & s_valid;
  assign m_rdata_bit   = in_read & tx_data;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
module tb_serial_bus_arbiter;

  localparam int NM   = 2;
  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int TO   = 16;
  localparam int L    = (AW > DW) ? AW : DW;
  localparam int W    = 2 + AW;
  localparam int TMAX = 96;

  logic          clk;
  logic          rstn;
  logic [NM-1:0] m_req, m_write, m_addr_bit, m_data_bit;
  logic [NM-1:0] m_grant, m_done;
  logic          m_timeout, m_rdata_bit, m_rdata_valid, bus_busy;
  logic          rx_address, rx_data, write_enable, read_enable, m_valid;
  logic          s_valid, tx_data;

  serial_bus_arbiter #(
    .N_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_write(m_write),
    .m_addr_bit(m_addr_bit), .m_data_bit(m_data_bit), .m_grant(m_grant),
    .m_done(m_done), .m_timeout(m_timeout), .m_rdata_bit(m_rdata_bit),
    .m_rdata_valid(m_rdata_valid), .bus_busy(bus_busy),
    .rx_address(rx_address), .rx_data(rx_data), .write_enable(write_enable),
    .read_enable(read_enable), .m_valid(m_valid), .s_valid(s_valid),
    .tx_data(tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int last_model = NM - 1;

  logic [NM-1:0] ob_grant [TMAX];
  logic [NM-1:0] ob_done  [TMAX];
  logic ob_to [TMAX], ob_mv [TMAX], ob_rxa [TMAX], ob_rxd [TMAX];
  logic ob_we [TMAX], ob_re [TMAX], ob_rv [TMAX], ob_rb [TMAX], ob_busy [TMAX];
  logic sv_s [TMAX], tx_s [TMAX];
  logic rst_all_zero;

  function automatic logic [NM-1:0] onehot(input int m);
    logic [NM-1:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  function automatic logic all_out_zero();
    return ({m_grant, m_done, m_timeout, m_rdata_bit, m_rdata_valid, bus_busy,
             rx_address, rx_data, write_enable, read_enable, m_valid} == '0);
  endfunction

  task automatic sample(input int t);
    ob_grant[t] = m_grant;  ob_done[t] = m_done;   ob_to[t] = m_timeout;
    ob_mv[t]    = m_valid;  ob_rxa[t]  = rx_address; ob_rxd[t] = rx_data;
    ob_we[t]    = write_enable; ob_re[t] = read_enable;
    ob_rv[t]    = m_rdata_valid; ob_rb[t] = m_rdata_bit; ob_busy[t] = bus_busy;
  endtask

  // Slave behaviour per cycle index (cycle 0 = IDLE cycle carrying the request).
  // delay < 0: write frame, noise only. delay >= TO: slave never answers.
  task automatic make_slave(input logic [DW-1:0] rd, input int delay, input int gap_pct);
    int t, n, gaps;
    for (int k = 0; k < TMAX; k++) begin
      sv_s[k] = 1'($urandom);
      tx_s[k] = 1'($urandom);
    end
    if (delay >= 0) begin
      for (int k = W; k < W + TO; k++) sv_s[k] = 1'b0;
      if (delay < TO) begin
        t = W + delay; n = 0; gaps = 0;
        while (n < DW && t < TMAX) begin
          if (n > 0 && gaps < 20 && $urandom_range(99) < gap_pct) begin
            sv_s[t] = 1'b0;
            gaps++;
          end else begin
            sv_s[t] = 1'b1;
            tx_s[t] = rd[n];
            n++;
          end
          t++;
        end
      end
    end
  endtask

  // Reference: first s_valid inside the TO-cycle WAIT window starts the read,
  // DW valid bits complete it, DONE is the following cycle.
  task automatic model_read(output int done_t, output bit to, output logic [DW-1:0] rd);
    int t, n;
    rd = '0; to = 1'b0; t = W;
    while (t < W + TO && !sv_s[t]) t++;
    if (t == W + TO) begin
      to = 1'b1;
      done_t = t;
    end else begin
      n = 0;
      while (n < DW && t < TMAX) begin
        if (sv_s[t]) begin rd[n] = tx_s[t]; n++; end
        t++;
      end
      done_t = t;
    end
  endtask

  task automatic run_frame(input int m, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input int req_len, input int rst_at);
    rst_all_zero = 1'b0;
    for (int t = 0; t < TMAX; t++) begin
      m_req = '0;
      if (t < req_len) m_req[m] = 1'b1;
      m_write    = NM'($urandom);
      m_write[m] = wr;
      m_addr_bit = NM'($urandom);
      m_data_bit = NM'($urandom);
      if (t >= 2 && t - 2 < AW) m_addr_bit[m] = addr[t-2];
      if (t >= 2 && t - 2 < DW) m_data_bit[m] = data[t-2];
      s_valid = sv_s[t];
      tx_data = tx_s[t];
      if (t == rst_at) begin
        rstn = 1'b0;
        #1;
        rst_all_zero = all_out_zero();
      end
      @(negedge clk);
      sample(t);
      @(posedge clk);
      #1;
      if (t == rst_at) rstn = 1'b1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    m_req = '0; m_write = '0; m_addr_bit = '1; m_data_bit = '1;
    s_valid = 1'b1; tx_data = 1'b1;
    #2;
    checks++;
    if (!all_out_zero()) begin
      errors++;
      $display("FAIL reset_outputs got grant=%b done=%b busy=%b mv=%b want all zero",
               m_grant, m_done, bus_busy, m_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", bus_busy);
    end
    s_valid = 1'b0;
    rstn = 1'b1;
    last_model = NM - 1;
  endtask

  task automatic test_write();
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    int nmv, nwe, nre, ndone;
    make_slave('0, -1, 0);
    run_frame(0, 1'b1, 12'hA5C, 8'h3B, 2, -1);
    last_model = 0;
    ga = '0; gd = '0; nmv = 0; nwe = 0; nre = 0; ndone = 0;
    for (int k = 0; k < AW; k++) ga[k] = ob_rxa[2+k];
    for (int k = 0; k < DW; k++) gd[k] = ob_rxd[2+k];
    for (int t = 0; t < TMAX; t++) begin
      nmv += int'(ob_mv[t]); nwe += int'(ob_we[t]); nre += int'(ob_re[t]);
      if (ob_done[t] != '0) ndone++;
    end
    checks++;
    if (ob_grant[0] !== 2'b00) begin errors++; $display("FAIL wr_grant_c0 got %b want 00", ob_grant[0]); end
    checks++;
    if (ob_grant[1] !== 2'b01) begin errors++; $display("FAIL wr_grant_c1 got %b want 01", ob_grant[1]); end
    checks++;
    if (ob_grant[13] !== 2'b01) begin errors++; $display("FAIL wr_grant_c13 got %b want 01", ob_grant[13]); end
    checks++;
    if (ob_we[2] !== 1'b1 || nwe != 1 || nre != 0) begin
      errors++; $display("FAIL wr_enable got we2=%b nwe=%0d nre=%0d want 1 1 0", ob_we[2], nwe, nre);
    end
    checks++;
    if (nmv != L || ob_mv[2] !== 1'b1 || ob_mv[13] !== 1'b1) begin
      errors++; $display("FAIL wr_mvalid got count=%0d want %0d", nmv, L);
    end
    checks++;
    if (ga !== 12'hA5C) begin errors++; $display("FAIL wr_addr got %h want a5c", ga); end
    checks++;
    if (gd !== 8'h3B) begin errors++; $display("FAIL wr_data got %h want 3b", gd); end
    checks++;
    if (ob_done[14] !== 2'b01 || ndone != 1 || ob_to[14] !== 1'b0) begin
      errors++; $display("FAIL wr_done got done14=%b n=%0d to=%b want 01 1 0", ob_done[14], ndone, ob_to[14]);
    end
    checks++;
    if (ob_grant[14] !== 2'b00 || ob_busy[14] !== 1'b1 || ob_busy[15] !== 1'b0) begin
      errors++; $display("FAIL wr_done_state got grant=%b busy14=%b busy15=%b want 00 1 0",
                         ob_grant[14], ob_busy[14], ob_busy[15]);
    end
  endtask

  task automatic test_read();
    logic [AW-1:0] ga;
    logic [DW-1:0] gr;
    int nre, nrv, nrxd, dt;
    make_slave(8'hC4, 2, 0);
    run_frame(1, 1'b0, 12'h123, 8'hFF, 1, -1);
    last_model = 1;
    ga = '0; gr = '0; nre = 0; nrv = 0; nrxd = 0; dt = -1;
    for (int k = 0; k < AW; k++) ga[k] = ob_rxa[2+k];
    for (int t = 0; t < TMAX; t++) begin
      nre += int'(ob_re[t]); nrxd += int'(ob_rxd[t]);
      if (ob_rv[t]) begin if (nrv < DW) gr[nrv] = ob_rb[t]; nrv++; end
      if (dt < 0 && ob_done[t] != '0) dt = t;
    end
    checks++;
    if (ob_re[2] !== 1'b1 || nre != 1) begin errors++; $display("FAIL rd_enable got re2=%b n=%0d want 1 1", ob_re[2], nre); end
    checks++;
    if (ga !== 12'h123 || nrxd != 0) begin errors++; $display("FAIL rd_addr got %h rxd=%0d want 123 0", ga, nrxd); end
    checks++;
    if (nrv != DW || gr !== 8'hC4) begin errors++; $display("FAIL rd_data got %h n=%0d want c4 8", gr, nrv); end
    checks++;
    if (dt != W + 2 + DW || (dt >= 0 && (ob_done[dt] !== 2'b10 || ob_to[dt] !== 1'b0))) begin
      errors++; $display("FAIL rd_done got cycle=%0d want %0d", dt, W + 2 + DW);
    end
  endtask

  task automatic test_timeout();
    int nrv, ndone;
    make_slave('0, TO, 0);
    run_frame(0, 1'b0, 12'h7E1, 8'h00, 1, -1);
    last_model = 0;
    nrv = 0; ndone = 0;
    for (int t = 0; t < TMAX; t++) begin
      nrv += int'(ob_rv[t]);
      if (ob_done[t] != '0) ndone++;
    end
    checks++;
    if (ob_done[W+TO] !== 2'b01 || ob_to[W+TO] !== 1'b1 || ndone != 1) begin
      errors++; $display("FAIL to_done got done=%b to=%b n=%0d want 01 1 1", ob_done[W+TO], ob_to[W+TO], ndone);
    end
    checks++;
    if (ob_done[W+TO-1] !== 2'b00 || ob_busy[W+TO] !== 1'b1 || ob_busy[W+TO+1] !== 1'b0) begin
      errors++; $display("FAIL to_timing got early_done=%b busy=%b%b want 00 10",
                         ob_done[W+TO-1], ob_busy[W+TO], ob_busy[W+TO+1]);
    end
    checks++;
    if (nrv != 0) begin errors++; $display("FAIL to_rvalid got %0d want 0", nrv); end
  endtask

  task automatic test_round_robin();
    int win;
    for (int t = 0; t < TMAX; t++) begin
      m_req = (t <= 45) ? '1 : '0;
      m_write = '1;
      m_addr_bit = NM'($urandom); m_data_bit = NM'($urandom);
      s_valid = 1'($urandom); tx_data = 1'($urandom);
      @(negedge clk);
      sample(t);
      @(posedge clk);
      #1;
    end
    for (int f = 0; f < 4; f++) begin
      win = (last_model + 1) % NM;
      last_model = win;
      checks++;
      if (ob_grant[1+15*f] !== onehot(win) || ob_grant[13+15*f] !== onehot(win)) begin
        errors++; $display("FAIL rr_grant frame %0d got %b want %b", f, ob_grant[1+15*f], onehot(win));
      end
      checks++;
      if (ob_done[14+15*f] !== onehot(win) || ob_busy[15+15*f] !== 1'b0 || ob_grant[15+15*f] !== '0) begin
        errors++; $display("FAIL rr_gap frame %0d got done=%b busy=%b want %b 0",
                           f, ob_done[14+15*f], ob_busy[15+15*f], onehot(win));
      end
    end
    checks++;
    if (ob_grant[61] !== '0 || ob_busy[61] !== 1'b0) begin
      errors++; $display("FAIL rr_stop got grant=%b busy=%b want 0 0", ob_grant[61], ob_busy[61]);
    end
  endtask

  task automatic test_req_drop();
    make_slave('0, -1, 0);
    run_frame(0, 1'b1, 12'h0F0, 8'h55, 6, -1);
    last_model = 0;
    checks++;
    if (ob_done[2+L] !== 2'b01 || ob_grant[8] !== 2'b01) begin
      errors++; $display("FAIL drop_done got done=%b grant8=%b want 01 01", ob_done[2+L], ob_grant[8]);
    end
  endtask

  task automatic test_rdata_gaps();
    logic [DW-1:0] gr, er;
    int nrv, dt, edt;
    bit eto;
    make_slave(8'hA7, 1, 45);
    model_read(edt, eto, er);
    run_frame(1, 1'b0, 12'h5A5, 8'h00, 1, -1);
    last_model = 1;
    gr = '0; nrv = 0; dt = -1;
    for (int t = 0; t < TMAX; t++) begin
      if (ob_rv[t]) begin if (nrv < DW) gr[nrv] = ob_rb[t]; nrv++; end
      if (dt < 0 && ob_done[t] != '0) dt = t;
    end
    checks++;
    if (nrv != DW || gr !== er) begin errors++; $display("FAIL gap_data got %h n=%0d want %h 8", gr, nrv, er); end
    checks++;
    if (dt != edt) begin errors++; $display("FAIL gap_done got cycle=%0d want %0d", dt, edt); end
  endtask

  task automatic test_reset_mid_rdata();
    int ndone, ra;
    ra = W + 3;
    make_slave(8'hFF, 0, 0);
    sv_s[ra] = 1'b1; tx_s[ra] = 1'b1;
    run_frame(0, 1'b0, 12'hFFF, 8'h00, 1, ra);
    last_model = NM - 1;
    ndone = 0;
    for (int t = 0; t < TMAX; t++) if (ob_done[t] != '0) ndone++;
    checks++;
    if (rst_all_zero !== 1'b1) begin errors++; $display("FAIL rst_mid_outputs got %b want 1", rst_all_zero); end
    checks++;
    if (ndone != 0 || ob_busy[ra+1] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_done got n=%0d busy=%b want 0 0", ndone, ob_busy[ra+1]);
    end
  endtask

  task automatic test_random_frames();
    int m, delay, dt, ndone, nrv, nre, nwe, nrxd, edt;
    bit wr, eto;
    logic [AW-1:0] addr, ga;
    logic [DW-1:0] data, gd, er;
    for (int f = 0; f < 24; f++) begin
      m     = $urandom_range(NM - 1);
      wr    = 1'($urandom);
      addr  = AW'($urandom);
      data  = DW'($urandom);
      delay = $urandom_range(19);
      make_slave(data, wr ? -1 : delay, $urandom_range(30));
      if (wr) begin
        edt = 2 + L; eto = 1'b0; er = '0;
      end else begin
        model_read(edt, eto, er);
      end
      run_frame(m, wr, addr, data, 1 + $urandom_range(9), -1);
      last_model = m;
      ga = '0; gd = '0; dt = -1; ndone = 0; nrv = 0; nre = 0; nwe = 0; nrxd = 0;
      for (int k = 0; k < AW; k++) ga[k] = ob_rxa[2+k];
      for (int t = 0; t < TMAX; t++) begin
        nre += int'(ob_re[t]); nwe += int'(ob_we[t]); nrxd += int'(ob_rxd[t]);
        if (ob_rv[t]) begin if (nrv < DW) gd[nrv] = ob_rb[t]; nrv++; end
        if (ob_done[t] != '0) begin ndone++; if (dt < 0) dt = t; end
      end
      if (wr) begin
        gd = '0;
        for (int k = 0; k < DW; k++) gd[k] = ob_rxd[2+k];
      end
      checks++;
      if (ob_grant[1] !== onehot(m) || ga !== addr) begin
        errors++; $display("FAIL rnd%0d_grant_addr got %b %h want %b %h", f, ob_grant[1], ga, onehot(m), addr);
      end
      checks++;
      if (dt != edt || ndone != 1 || (dt >= 0 && ob_done[dt] !== onehot(m))) begin
        errors++; $display("FAIL rnd%0d_done got cycle=%0d n=%0d want %0d 1", f, dt, ndone, edt);
      end
      checks++;
      if (dt >= 0 && ob_to[dt] !== eto) begin
        errors++; $display("FAIL rnd%0d_timeout got %b want %b", f, ob_to[dt], eto);
      end
      checks++;
      if (ob_we[2] !== wr || ob_re[2] !== !wr || nwe + nre != 1) begin
        errors++; $display("FAIL rnd%0d_strobe got we=%b re=%b want wr=%b", f, ob_we[2], ob_re[2], wr);
      end
      checks++;
      if (wr ? (gd !== data || nrv != 0) : (nrxd != 0 || nrv != (eto ? 0 : DW) || gd !== er)) begin
        errors++; $display("FAIL rnd%0d_data got %h n=%0d want %h", f, gd, nrv, wr ? data : er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_req_drop();
    test_rdata_gaps();
    test_reset_mid_rdata();
    test_round_robin();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
